rect_raster_engine: RTL and testbench

Parametrised successor to the single-mode rectangle filler. Accepts a 12-byte draw command from the command processor over an rts/rtr byte stream and clips the rectangle to the framebuffer. Rasterises it as a solid fill or a 1-pixel outline, and issues word-merged, byte-enabled 32-bit writes to the memory arbiter at up to one word per cycle. Pixel depth, framebuffer geometry and base address are parameters.

---
 rtl/rect_raster_engine_pkg.sv | 38 +++
 rtl/rect_raster_engine_if.sv | 25 ++
 rtl/rect_span_mask.sv | 26 ++
 rtl/rect_raster_engine.sv | 199 +++++++++++++++++++
 tb/tb_rect_raster_engine.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rect_raster_engine_pkg.sv
// Shared types, command layout and colour packing for the rectangle raster engine.
package rect_pkg;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  typedef enum logic [1:0] {
    RECV = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Byte positions within the 12-byte draw command.
  localparam logic [3:0] IDX_MODE = 4'd0;
  localparam logic [3:0] IDX_X_HI = 4'd1;
  localparam logic [3:0] IDX_X_LO = 4'd2;
  localparam logic [3:0] IDX_Y_HI = 4'd3;
  localparam logic [3:0] IDX_Y_LO = 4'd4;
  localparam logic [3:0] IDX_W_HI = 4'd5;
  localparam logic [3:0] IDX_W_LO = 4'd6;
  localparam logic [3:0] IDX_H_HI = 4'd7;
  localparam logic [3:0] IDX_H_LO = 4'd8;
  localparam logic [3:0] IDX_R    = 4'd9;
  localparam logic [3:0] IDX_G    = 4'd10;
  localparam logic [3:0] IDX_B    = 4'd11;

  // Packs one pixel and replicates it across all lanes of a 32-bit word.
  function automatic logic [31:0] pack_color(input int bpp, input logic [7:0] r,
                                             input logic [7:0] g, input logic [7:0] b);
    case (bpp)
      8:       return {4{r[7:5], g[7:5], b[7:6]}};
      16:      return {2{r[7:3], g[7:2], b[7:3]}};
      default: return {8'h00, r, g, b};
    endcase
  endfunction

endpackage

// File: rtl/rect_raster_engine_if.sv
// Command byte stream and arbiter write port of the rectangle raster engine.
interface rect_cmd_if;
  logic [7:0] cmd_in_data;
  logic       cmd_in_rts;
  logic       cmd_out_rtr;

  modport master (output cmd_in_data, output cmd_in_rts, input cmd_out_rtr);
  modport slave  (input cmd_in_data, input cmd_in_rts, output cmd_out_rtr);
endinterface

interface rect_arb_if #(
  parameter int ADDR_W = 16
);
  logic [31:0]       arb_out_data;
  logic [ADDR_W-1:0] arb_out_addr;
  logic [3:0]        arb_out_wben;
  logic              arb_out_rts;
  logic              arb_in_rtr;
  logic              arb_out_op;

  modport master (output arb_out_data, output arb_out_addr, output arb_out_wben,
                  output arb_out_rts, input arb_in_rtr, output arb_out_op);
  modport slave  (input arb_out_data, input arb_out_addr, input arb_out_wben,
                  input arb_out_rts, output arb_in_rtr, input arb_out_op);
endinterface

// File: rtl/rect_span_mask.sv
// Byte-enable mask for one framebuffer word given a half-open linear pixel span.
module rect_span_mask #(
  parameter int BPP    = 8,
  parameter int ADDR_W = 16,
  parameter int LIN_W  = 18
) (
  input  logic [ADDR_W-1:0] word_idx,
  input  logic [LIN_W-1:0]  span_start,
  input  logic [LIN_W-1:0]  span_end,
  output logic [3:0]        wben
);

  localparam int BYTES_PP = BPP / 8;
  localparam int SH       = $clog2(32 / BPP);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      localparam int LANE = gi / BYTES_PP;
      logic [LIN_W-1:0] pix;
      assign pix      = (LIN_W'(word_idx) << SH) | LIN_W'(LANE);
      assign wben[gi] = (pix >= span_start) && (pix < span_end);
    end
  endgenerate

endmodule

// File: rtl/rect_raster_engine.sv
// Receives a draw command, clips it to the framebuffer and streams word-merged
// byte-enabled writes for a solid fill or a one-pixel outline.
module rect_raster_engine #(
  parameter int FB_W      = 320,
  parameter int FB_H      = 240,
  parameter int BPP       = 8,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  rect_cmd_if.slave  cmd,
  rect_arb_if.master arb,
  output logic       draw_done
);
  import rect_pkg::*;

  localparam int PPW   = 32 / BPP;
  localparam int SH    = $clog2(PPW);
  localparam int LIN_W = ADDR_W + SH;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg;
  logic              mode_reg;
  logic [15:0]       x_reg, y_reg, w_reg, h_reg;
  logic [7:0]        r_reg, g_reg, b_reg;
  logic              calc_step_reg;
  logic              drain_reg;
  logic              empty_reg;
  logic [16:0]       xe_reg, ye_reg, row_reg;
  logic [LIN_W-1:0]  row_base_reg;
  logic [ADDR_W-1:0] cur_word_reg;
  logic [31:0]       color_reg;

  logic              cmd_xfer, arb_xfer, emit_active;
  logic [16:0]       x_plus_w, y_plus_h, xe_calc, ye_calc;
  logic              empty_calc;
  logic              edge_row, right_in, has_sec;
  logic              row_is_last, word_is_last;
  logic [LIN_W-1:0]  lin_left, lin_right, lin_end, lin_last;
  logic [LIN_W-1:0]  span0_end, span1_end;
  logic [ADDR_W-1:0] word_first, word_right, word_last, next_word_first;
  logic [3:0]        mask0, mask1;

  assign cmd_xfer    = (state_reg == RECV) && cmd.cmd_in_rts;
  assign emit_active = (state_reg == EMIT) && !drain_reg;
  assign arb_xfer    = emit_active && arb.arb_in_rtr;

  assign x_plus_w   = {1'b0, x_reg} + {1'b0, w_reg};
  assign y_plus_h   = {1'b0, y_reg} + {1'b0, h_reg};
  assign xe_calc    = (x_plus_w > 17'(FB_W)) ? 17'(FB_W) : x_plus_w;
  assign ye_calc    = (y_plus_h > 17'(FB_H)) ? 17'(FB_H) : y_plus_h;
  assign empty_calc = (w_reg == 16'd0) || (h_reg == 16'd0) ||
                      (x_reg >= 16'(FB_W)) || (y_reg >= 16'(FB_H));

  // Top and (unclipped) bottom rows of an outline are drawn like fill rows.
  assign edge_row = (mode_reg == MODE_FILL) || (row_reg == {1'b0, y_reg}) ||
                    (row_reg + 17'd1 == y_plus_h);
  assign right_in = (x_plus_w <= 17'(FB_W));
  assign has_sec  = !edge_row && right_in;

  assign lin_left  = row_base_reg + LIN_W'(x_reg);
  assign lin_right = lin_left + LIN_W'(w_reg) - LIN_W'(1);
  assign lin_end   = row_base_reg + LIN_W'(xe_reg);
  assign span0_end = edge_row ? lin_end : lin_left + LIN_W'(1);
  assign span1_end = has_sec ? lin_right + LIN_W'(1) : lin_right;
  assign lin_last  = edge_row ? lin_end - LIN_W'(1) : (has_sec ? lin_right : lin_left);

  assign word_first      = ADDR_W'(lin_left >> SH);
  assign word_right      = ADDR_W'(lin_right >> SH);
  assign word_last       = ADDR_W'(lin_last >> SH);
  assign next_word_first = ADDR_W'((lin_left + LIN_W'(FB_W)) >> SH);

  assign row_is_last  = (row_reg + 17'd1 == ye_reg);
  assign word_is_last = (cur_word_reg == word_last);

  rect_span_mask #(.BPP(BPP), .ADDR_W(ADDR_W), .LIN_W(LIN_W)) u_mask_main (
    .word_idx  (cur_word_reg),
    .span_start(lin_left),
    .span_end  (span0_end),
    .wben      (mask0)
  );

  // Right-hand outline pixel; collapses to an empty span when not present.
  rect_span_mask #(.BPP(BPP), .ADDR_W(ADDR_W), .LIN_W(LIN_W)) u_mask_right (
    .word_idx  (cur_word_reg),
    .span_start(lin_right),
    .span_end  (span1_end),
    .wben      (mask1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RECV;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RECV: if (cmd_xfer && (cnt_reg == IDX_B)) state_next = CALC;
      CALC: if (calc_step_reg) state_next = empty_reg ? DONE : EMIT;
      EMIT: if (drain_reg) state_next = DONE;
      DONE: state_next = RECV;
      default: state_next = RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= 4'd0;
      mode_reg      <= 1'b0;
      x_reg         <= 16'd0;
      y_reg         <= 16'd0;
      w_reg         <= 16'd0;
      h_reg         <= 16'd0;
      r_reg         <= 8'd0;
      g_reg         <= 8'd0;
      b_reg         <= 8'd0;
      calc_step_reg <= 1'b0;
      drain_reg     <= 1'b0;
      empty_reg     <= 1'b0;
      xe_reg        <= 17'd0;
      ye_reg        <= 17'd0;
      row_reg       <= 17'd0;
      row_base_reg  <= '0;
      cur_word_reg  <= '0;
      color_reg     <= 32'd0;
    end else begin
      case (state_reg)
        RECV: begin
          if (cmd_xfer) begin
            cnt_reg <= (cnt_reg == IDX_B) ? 4'd0 : cnt_reg + 4'd1;
            case (cnt_reg)
              IDX_MODE: mode_reg     <= cmd.cmd_in_data[0];
              IDX_X_HI: x_reg[15:8]  <= cmd.cmd_in_data;
              IDX_X_LO: x_reg[7:0]   <= cmd.cmd_in_data;
              IDX_Y_HI: y_reg[15:8]  <= cmd.cmd_in_data;
              IDX_Y_LO: y_reg[7:0]   <= cmd.cmd_in_data;
              IDX_W_HI: w_reg[15:8]  <= cmd.cmd_in_data;
              IDX_W_LO: w_reg[7:0]   <= cmd.cmd_in_data;
              IDX_H_HI: h_reg[15:8]  <= cmd.cmd_in_data;
              IDX_H_LO: h_reg[7:0]   <= cmd.cmd_in_data;
              IDX_R:    r_reg        <= cmd.cmd_in_data;
              IDX_G:    g_reg        <= cmd.cmd_in_data;
              IDX_B:    b_reg        <= cmd.cmd_in_data;
              default: ;
            endcase
          end
        end
        CALC: begin
          if (!calc_step_reg) begin
            xe_reg        <= xe_calc;
            ye_reg        <= ye_calc;
            empty_reg     <= empty_calc;
            row_reg       <= {1'b0, y_reg};
            row_base_reg  <= LIN_W'(y_reg) * LIN_W'(FB_W);
            color_reg     <= pack_color(BPP, r_reg, g_reg, b_reg);
            calc_step_reg <= 1'b1;
          end else begin
            calc_step_reg <= 1'b0;
            cur_word_reg  <= word_first;
            drain_reg     <= 1'b0;
          end
        end
        EMIT: begin
          if (arb_xfer) begin
            if (word_is_last) begin
              if (row_is_last) begin
                drain_reg <= 1'b1;
              end else begin
                row_reg      <= row_reg + 17'd1;
                row_base_reg <= row_base_reg + LIN_W'(FB_W);
                cur_word_reg <= next_word_first;
              end
            end else begin
              // Interior outline rows jump straight to the right-hand pixel's word.
              cur_word_reg <= has_sec ? word_right : cur_word_reg + ADDR_W'(1);
            end
          end else if (drain_reg) begin
            drain_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd.cmd_out_rtr  = (state_reg == RECV);
  assign arb.arb_out_rts  = emit_active;
  assign arb.arb_out_op   = emit_active;
  assign arb.arb_out_addr = emit_active ? ADDR_W'(BASE_ADDR) + cur_word_reg : '0;
  assign arb.arb_out_data = emit_active ? color_reg : 32'd0;
  assign arb.arb_out_wben = emit_active ? (mask0 | mask1) : 4'd0;
  assign draw_done        = (state_reg == DONE);

endmodule

// File: tb/tb_rect_raster_engine.sv
// Scoreboard bench for rect_raster_engine: directed draw commands with
// hand-computed expected writes, checked by an independent write monitor.
module tb_rect_raster_engine;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  wben;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic draw_done;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rect_cmd_if cmd_if ();
  rect_arb_if #(.ADDR_W(16)) arb_if ();

  rect_raster_engine #(
    .FB_W(320), .FB_H(240), .BPP(8), .BASE_ADDR(0), .ADDR_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_if),
    .arb      (arb_if),
    .draw_done(draw_done)
  );

  int  n_vec = 0;
  int  n_miss = 0;
  bit  ignore_wr = 1'b0;
  bit  bp_en = 1'b0;
  int  last_xfer = 0;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.wben = be;
    exp_q.push_back(e);
  endtask

  // Arbiter ready: always 1, or random when backpressure is enabled.
  initial begin
    arb_if.arb_in_rtr = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      arb_if.arb_in_rtr = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Write monitor: pops the scoreboard on each transfer, checks stalls hold.
  initial begin
    wr_t got, want, held;
    bit  holding;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      if (ignore_wr || rst) begin
        holding = 1'b0;
      end else begin
        got.addr = arb_if.arb_out_addr;
        got.data = arb_if.arb_out_data;
        got.wben = arb_if.arb_out_wben;
        if (holding) begin
          check("hold_rts", 32'(arb_if.arb_out_rts), 32'd1);
          check("hold_word", {12'd0, got.addr, got.wben}, {12'd0, held.addr, held.wben});
          check("hold_data", got.data, held.data);
        end
        if (arb_if.arb_out_rts) begin
          check("op", 32'(arb_if.arb_out_op), 32'd1);
          if (arb_if.arb_in_rtr) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_miss++;
              $display("FAIL unexpected_write: got addr %h data %h wben %b, required none",
                       got.addr, got.data, got.wben);
            end else begin
              want = exp_q.pop_front();
              check("wr_addr", 32'(got.addr), 32'(want.addr));
              check("wr_data", got.data, want.data);
              check("wr_wben", 32'(got.wben), 32'(want.wben));
            end
            last_xfer = cyc;
            holding = 1'b0;
          end else begin
            held = got;
            holding = 1'b1;
          end
        end else begin
          holding = 1'b0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte's transfer edge.
  task automatic send_byte(input logic [7:0] b, output int e);
    int t;
    t = 0;
    cmd_if.cmd_in_data = b;
    cmd_if.cmd_in_rts = 1'b1;
    while (!cmd_if.cmd_out_rtr && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_if.cmd_out_rtr) begin
      n_vec++;
      n_miss++;
      $display("FAIL cmd_rtr_timeout: cmd_out_rtr stayed 0 for %0d cycles, required 1", t);
    end
    e = cyc + 1;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] mode, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] w, input logic [15:0] h, input logic [7:0] r,
                          input logic [7:0] g, input logic [7:0] b, input bit gap,
                          output int e);
    logic [7:0] bytes [12];
    bytes = '{mode, x[15:8], x[7:0], y[15:8], y[7:0], w[15:8], w[7:0],
              h[15:8], h[7:0], r, g, b};
    for (int i = 0; i < 12; i++) begin
      if (gap && i == 5) begin
        cmd_if.cmd_in_rts = 1'b0;
        repeat (3) @(negedge clk);
      end
      send_byte(bytes[i], e);
    end
    cmd_if.cmd_in_rts = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    int t;
    t = 0;
    while (!draw_done && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (!draw_done) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_timeout: draw_done 0 after %0d cycles, required 1", budget);
      dc = -1;
    end else begin
      dc = cyc;
    end
  endtask

  task automatic finish_cmd(input string name);
    int dc;
    wait_done(500, dc);
    check({name, "_rtr_in_done"}, 32'(cmd_if.cmd_out_rtr), 32'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(draw_done), 32'd0);
    check({name, "_rtr_back"}, 32'(cmd_if.cmd_out_rtr), 32'd1);
    check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rtr"}, 32'(cmd_if.cmd_out_rtr), 32'd1);
    check({name, "_rts"}, 32'(arb_if.arb_out_rts), 32'd0);
    check({name, "_op"}, 32'(arb_if.arb_out_op), 32'd0);
    check({name, "_data"}, arb_if.arb_out_data, 32'd0);
    check({name, "_addr"}, 32'(arb_if.arb_out_addr), 32'd0);
    check({name, "_wben"}, 32'(arb_if.arb_out_wben), 32'd0);
    check({name, "_done"}, 32'(draw_done), 32'd0);
  endtask

  task automatic run_test1(input string name);
    int e, dc;
    expect_wr(16'h0A08, 32'hE0E0E0E0, 4'b1111);
    send_cmd(8'h00, 16'h20, 16'h20, 16'd4, 16'd1, 8'hFF, 8'h00, 8'h00, 1'b0, e);
    @(negedge clk);
    check({name, "_rts_in_calc"}, 32'(arb_if.arb_out_rts), 32'd0);
    @(negedge clk);
    check({name, "_rts_start"}, 32'(arb_if.arb_out_rts), 32'd1);
    wait_done(100, dc);
    check({name, "_done_latency"}, 32'(dc - last_xfer), 32'd2);
    check({name, "_rtr_in_done"}, 32'(cmd_if.cmd_out_rtr), 32'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(draw_done), 32'd0);
    check({name, "_rtr_back"}, 32'(cmd_if.cmd_out_rtr), 32'd1);
    check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic push_test2();
    expect_wr(16'd0,  32'h1C1C1C1C, 4'b1110);
    expect_wr(16'd1,  32'h1C1C1C1C, 4'b0111);
    expect_wr(16'd80, 32'h1C1C1C1C, 4'b1110);
    expect_wr(16'd81, 32'h1C1C1C1C, 4'b0111);
  endtask

  initial begin
    int e, dc;
    cmd_if.cmd_in_data = 8'd0;
    cmd_if.cmd_in_rts = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_test1("fill_1row");

    push_test2();
    send_cmd(8'h00, 16'd1, 16'd0, 16'd6, 16'd2, 8'h00, 8'hFF, 8'h00, 1'b1, e);
    finish_cmd("fill_2row_gap");

    expect_wr(16'd0,   32'h03030303, 4'b1111);
    expect_wr(16'd1,   32'h03030303, 4'b1111);
    expect_wr(16'd80,  32'h03030303, 4'b0001);
    expect_wr(16'd81,  32'h03030303, 4'b1000);
    expect_wr(16'd160, 32'h03030303, 4'b1111);
    expect_wr(16'd161, 32'h03030303, 4'b1111);
    send_cmd(8'h01, 16'd0, 16'd0, 16'd8, 16'd3, 8'h00, 8'h00, 8'hFF, 1'b0, e);
    finish_cmd("outline_8x3");

    expect_wr(16'd19199, 32'hFFFFFFFF, 4'b1100);
    send_cmd(8'h00, 16'd318, 16'd239, 16'd10, 16'd10, 8'hFF, 8'hFF, 8'hFF, 1'b0, e);
    finish_cmd("clip_corner");

    expect_wr(16'd81,  32'h03030303, 4'b0010);
    expect_wr(16'd161, 32'h03030303, 4'b0010);
    expect_wr(16'd241, 32'h03030303, 4'b0010);
    send_cmd(8'hFF, 16'd5, 16'd1, 16'd1, 16'd3, 8'h00, 8'h00, 8'hFF, 1'b0, e);
    finish_cmd("outline_w1");

    expect_wr(16'd879,  32'hE0E0E0E0, 4'b1100);
    expect_wr(16'd959,  32'hE0E0E0E0, 4'b0100);
    expect_wr(16'd1039, 32'hE0E0E0E0, 4'b1100);
    send_cmd(8'h01, 16'd318, 16'd10, 16'd5, 16'd3, 8'hFF, 8'h00, 8'h00, 1'b0, e);
    finish_cmd("outline_rclip");

    send_cmd(8'h00, 16'd10, 16'd10, 16'd0, 16'd5, 8'hFF, 8'hFF, 8'hFF, 1'b0, e);
    wait_done(50, dc);
    check("empty_done_latency", 32'(dc - e), 32'd2);
    @(negedge clk);
    check("empty_rtr_back", 32'(cmd_if.cmd_out_rtr), 32'd1);

    bp_en = 1'b1;
    push_test2();
    send_cmd(8'h00, 16'd1, 16'd0, 16'd6, 16'd2, 8'h00, 8'hFF, 8'h00, 1'b0, e);
    finish_cmd("fill_backpressure");
    bp_en = 1'b0;
    repeat (2) @(negedge clk);

    ignore_wr = 1'b1;
    send_cmd(8'h00, 16'd0, 16'd0, 16'd320, 16'd100, 8'hFF, 8'hFF, 8'hFF, 1'b0, e);
    repeat (30) @(negedge clk);
    check("big_fill_emitting", 32'(arb_if.arb_out_rts), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_draw_reset");
    rst = 1'b0;
    ignore_wr = 1'b0;
    @(negedge clk);
    run_test1("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

endmodule
